// File: rtl/regwrite_arbiter.sv
// rtl/regwrite_arbiter.sv - round-robin arbiter for the register bank write port with locked bursts
module regwrite_arbiter #(
  parameter int NREQ      = 4,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int MAX_BEATS = 8
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ-1:0]    req_clr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic               wr_ena,
  output logic               wr_clr,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic            beat_valid;
  logic [PW-1:0]   beat_idx;

  logic [NREQ-1:0] gnt_d;
  logic            ena_d, clr_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   data_d;

  // Index after i, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    else return i + 1'b1;
  endfunction

  // Round-robin scan starting at ptr; the lowest offset with a request wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx[PW-1:0];
      end
    end
  end

  // Next-state: pick the beat for this edge and update ptr/owner/beat count.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    beat_valid = 1'b0;
    beat_idx   = win_idx;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          beat_valid = 1'b1;
          if (lock[win_idx] && (MAX_BEATS > 1)) begin
            state_d = OWN;
            owner_d = win_idx;
            cnt_d   = CW'(1);
          end else begin
            ptr_d = next_idx(win_idx);
          end
        end
      end
      OWN: begin
        beat_idx = owner_q;
        if (!req[owner_q]) begin
          // Owner walked away: release without a beat.
          state_d = IDLE;
          ptr_d   = next_idx(owner_q);
          cnt_d   = '0;
        end else begin
          beat_valid = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          // Unlocked beat is the last of the burst; the cap forces release too.
          if (!lock[owner_q] || (cnt_q == CW'(MAX_BEATS - 1))) begin
            state_d = IDLE;
            ptr_d   = next_idx(owner_q);
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode for the chosen beat; address 0 is never written or cleared.
  always_comb begin
    gnt_d  = '0;
    ena_d  = 1'b0;
    clr_d  = 1'b0;
    addr_d = '0;
    data_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (beat_valid && (int'(beat_idx) == i)) begin
        gnt_d[i] = 1'b1;
        addr_d   = req_addr[i*AW +: AW];
        if (!req_clr[i]) data_d = req_data[i*DW +: DW];
        if (req_addr[i*AW +: AW] != '0) begin
          if (req_clr[i]) clr_d = 1'b1;
          else            ena_d = 1'b1;
        end
      end
    end
  end

  // State and registered outputs; reset drops everything, including a burst.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      ack     <= '0;
      wr_ena  <= 1'b0;
      wr_clr  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      ack     <= gnt_d;
      wr_ena  <= ena_d;
      wr_clr  <= clr_d;
      wr_addr <= addr_d;
      wr_data <= data_d;
    end
  end

  assign busy = (state_q == OWN);

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb/tb_regwrite_arbiter.sv - self-checking bench for regwrite_arbiter
module tb_regwrite_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               clrn;
  logic [NREQ-1:0]    req, lock, req_clr;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt, ack;
  logic               wr_ena, wr_clr, busy;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;

  logic [AW-1:0] tb_addr [NREQ];
  logic [DW-1:0] tb_data [NREQ];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] lock;
    logic [NREQ-1:0] clr;
    logic [NREQ-1:0] exp_gnt;
    logic            exp_busy;
  } vec_t;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic            ena;
    logic            clr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic            busy;
  } exp_t;

  vec_t vecs [25];
  exp_t sb [$];

  regwrite_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BEATS(8)) dut (
    .clk(clk), .clrn(clrn), .req(req), .lock(lock), .req_clr(req_clr),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .ack(ack),
    .wr_ena(wr_ena), .wr_clr(wr_clr), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Pack per-requester fields onto the flat buses.
  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = tb_addr[i];
      req_data[i*DW +: DW] = tb_data[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for the coming edge and queue the outputs that edge must produce.
  task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                       input logic [NREQ-1:0] c, input logic [NREQ-1:0] g, input logic b);
    exp_t e;
    req = r; lock = l; req_clr = c;
    e.gnt = g; e.ena = 1'b0; e.clr = 1'b0; e.addr = '0; e.data = '0; e.busy = b;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        e.addr = tb_addr[i];
        if (!c[i]) e.data = tb_data[i];
        if (tb_addr[i] != '0) begin
          if (c[i]) e.clr = 1'b1;
          else      e.ena = 1'b1;
        end
      end
    end
    sb.push_back(e);
  endtask

  // Let the edge happen, then compare against the oldest queued expectation.
  task automatic check_edge(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".gnt"},     32'(gnt),     32'(e.gnt));
      chk({tag, ".ack"},     32'(ack),     32'(e.gnt));
      chk({tag, ".wr_ena"},  32'(wr_ena),  32'(e.ena));
      chk({tag, ".wr_clr"},  32'(wr_clr),  32'(e.clr));
      chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(e.addr));
      chk({tag, ".wr_data"}, 32'(wr_data), 32'(e.data));
      chk({tag, ".busy"},    32'(busy),    32'(e.busy));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".gnt"},     32'(gnt),     32'd0);
    chk({tag, ".ack"},     32'(ack),     32'd0);
    chk({tag, ".wr_ena"},  32'(wr_ena),  32'd0);
    chk({tag, ".wr_clr"},  32'(wr_clr),  32'd0);
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, ".wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, ".busy"},    32'(busy),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // RR fairness over two rounds
    for (int i = 0; i < 8; i++)
      vecs[i] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001 << (i % 4), 1'b0};
    // Burst cap: 8 locked beats by requester 2, then requester 3
    for (int i = 8; i < 15; i++)
      vecs[i] = '{4'b1100, 4'b0100, 4'b0000, 4'b0100, 1'b1};
    vecs[15] = '{4'b1100, 4'b0100, 4'b0000, 4'b0100, 1'b0};
    vecs[16] = '{4'b1100, 4'b0000, 4'b0000, 4'b1000, 1'b0};
    // Early unlock on the third beat, then ptr must sit at 2
    vecs[17] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1};
    vecs[18] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1};
    vecs[19] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0};
    vecs[20] = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0};
    // Owner drops req while owning
    vecs[21] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1};
    vecs[22] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1};
    vecs[23] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[24] = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0};

    tb_addr[0] = 5'd3;  tb_data[0] = 32'h1111_0000;
    tb_addr[1] = 5'd9;  tb_data[1] = 32'h2222_0001;
    tb_addr[2] = 5'd5;  tb_data[2] = 32'hA5A5_A5A5;
    tb_addr[3] = 5'd12; tb_data[3] = 32'h4444_0003;

    clrn = 1'b0; req = 4'b1111; lock = 4'b1111; req_clr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    clrn = 1'b1;

    for (int v = 0; v < 25; v++) begin
      drive(vecs[v].req, vecs[v].lock, vecs[v].clr, vecs[v].exp_gnt, vecs[v].exp_busy);
      check_edge($sformatf("vec%0d", v));
    end

    // Address 0 beat: acked, but the bank is not touched
    tb_addr[1] = 5'd0; tb_data[1] = 32'hFFFF_FFFF;
    drive(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    check_edge("zero_addr");
    // Clear beat: wr_clr with zero data
    tb_addr[3] = 5'd7;
    drive(4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b0);
    check_edge("clear");
    chk("clear.wr_addr_is_7", 32'(wr_addr), 32'd7);

    // Async reset in the middle of a locked burst
    drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    check_edge("pre_reset");
    #3;
    clrn = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    clrn = 1'b1;
    drive(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    check_edge("after_reset");

    req = '0; lock = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
